// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) arbiter onto an asynchronous SRAM; each access holds the bus for WAIT_STATES+1 cycles.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build gives the CPU fixed priority.
module mem_arbiter #(
  parameter int WAIT_STATES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [19:0] i_cpu_addr,
  input  logic [15:0] i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [15:0] o_cpu_rdata,
  input  logic        i_ld_req,
  input  logic        i_ld_we,
  input  logic [19:0] i_ld_addr,
  input  logic [15:0] i_ld_wdata,
  output logic        o_ld_ack,
  output logic [15:0] o_ld_rdata,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_dq_out,
  output logic        o_sram_dq_oe,
  input  logic [15:0] i_sram_dq_in,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  localparam logic [2:0] LP_WS = 3'(WAIT_STATES);

  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic        r_grant;  // 0 = CPU, 1 = loader
  logic        r_we;
  logic [19:0] r_addr;
  logic [15:0] r_wdata, r_cpu_rdata, r_ld_rdata;
  logic        w_go, w_win, w_start;

  assign w_go    = i_cpu_req | i_ld_req;
  assign w_start = (r_state == S_IDLE) && w_go;

`ifdef MEM_ARB_RR_EN
  logic r_last;
  // On a tie the port that did not win last time goes first.
  assign w_win = (i_cpu_req & i_ld_req) ? ~r_last : ~i_cpu_req;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)     r_last <= 1'b0;
    else if (w_start) r_last <= w_win;
`else
  assign w_win = ~i_cpu_req;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_go) w_next = S_ACCESS;
      S_ACCESS: if (r_cnt == 3'd0) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Request inputs are only looked at in IDLE; everything after is driven from latched copies.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= 3'd0;
      r_grant     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 20'd0;
      r_wdata     <= 16'd0;
      r_cpu_rdata <= 16'd0;
      r_ld_rdata  <= 16'd0;
    end else if (w_start) begin
      r_cnt   <= LP_WS;
      r_grant <= w_win;
      r_we    <= w_win ? i_ld_we    : i_cpu_we;
      r_addr  <= w_win ? i_ld_addr  : i_cpu_addr;
      r_wdata <= w_win ? i_ld_wdata : i_cpu_wdata;
    end else if (r_state == S_ACCESS) begin
      if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
      else if (!r_we) begin
        if (r_grant) r_ld_rdata  <= i_sram_dq_in;
        else         r_cpu_rdata <= i_sram_dq_in;
      end
    end
  end

  // Strobes decode straight from state so an async reset releases them without a clock.
  always_comb begin
    o_sram_ce_n  = 1'b1;
    o_sram_oe_n  = 1'b1;
    o_sram_we_n  = 1'b1;
    o_sram_dq_oe = 1'b0;
    if (r_state == S_ACCESS) begin
      o_sram_ce_n = 1'b0;
      if (r_we) begin
        o_sram_dq_oe = 1'b1;
        o_sram_we_n  = (r_cnt == 3'd0);  // last cycle is the data hold cycle
      end else begin
        o_sram_oe_n = 1'b0;
      end
    end
  end

  assign o_sram_addr   = r_addr;
  assign o_sram_dq_out = r_wdata;
  assign o_cpu_ack     = (r_state == S_DONE) & ~r_grant;
  assign o_ld_ack      = (r_state == S_DONE) &  r_grant;
  assign o_cpu_rdata   = r_cpu_rdata;
  assign o_ld_rdata    = r_ld_rdata;
endmodule
